// File: rtl/sync_pkg.sv
// Shared defaults and helpers for the sync_filter input conditioner.
package sync_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_FILTER_DEF = 4;

  // Filter counter width for a filter that needs n agreeing samples.
  function automatic int filt_cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// Single-channel glitch filter: accepts a new level only after FILTER_CYCLES
// consecutive disagreeing samples, and strobes rise/fall on acceptance.
module glitch_filter
  import sync_pkg::*;
#(
  parameter int FILTER_CYCLES = SYNC_FILTER_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int CW = filt_cnt_w(FILTER_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  if (FILTER_CYCLES < 1) begin : g_bad_cycles
    $error("glitch_filter: FILTER_CYCLES must be >= 1");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= rst_val;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (d == q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        q    <= d;
        cnt  <= '0;
        rise <= d;
        fall <= ~d;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sync_filter.sv
// Multi-channel synchronizer with optional per-channel glitch filter
// (enabled by defining SYNC_FILTER_EN) and registered rise/fall strobes.
module sync_filter
  import sync_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter int               STAGES        = SYNC_STAGES_DEF,
  parameter int               FILTER_CYCLES = SYNC_FILTER_DEF,
  parameter logic [WIDTH-1:0] RST_VAL       = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter: STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_cycles
    $error("sync_filter: FILTER_CYCLES must be >= 1");
  end

`ifdef SYNC_FILTER_EN
  localparam int NSYNC = STAGES;
`else
  // Without the filter the dout register is itself the last sync stage,
  // giving a latency of exactly STAGES cycles.
  localparam int NSYNC = STAGES - 1;
`endif

  logic [WIDTH-1:0] sync_q [NSYNC];
  logic [WIDTH-1:0] sync_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NSYNC; k++) sync_q[k] <= RST_VAL;
    end else begin
      sync_q[0] <= din;
      for (int unsigned k = 1; k < NSYNC; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_out = sync_q[NSYNC-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
`ifdef SYNC_FILTER_EN
    glitch_filter #(
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[i]),
      .d       (sync_out[i]),
      .q       (dout[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
`else
    always_ff @(posedge clk) begin
      if (rst) begin
        dout[i] <= RST_VAL[i];
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
      end else begin
        dout[i] <= sync_out[i];
        rise[i] <= sync_out[i] & ~dout[i];
        fall[i] <= ~sync_out[i] & dout[i];
      end
    end
`endif
  end

endmodule

// File: doc/sync_filter.md
# sync_filter

Parametrised multi-channel input conditioner: each of WIDTH asynchronous inputs passes through a STAGES-deep flip-flop synchronizer. An optional per-channel glitch filter follows. Single-cycle rise/fall strobes are produced on the conditioned level. It sits between the UART pins (rx, cts, and other external strobes) and the receiver and control logic, replacing fixed two-stage synchronizers.

## Interface
- WIDTH, 4: number of independent channels.
- STAGES, 2: synchronizer depth; must be >= 2, elaboration error otherwise.
- FILTER_CYCLES, 4: consecutive agreeing samples required to accept a new level; must be >= 1. Used only with SYNC_FILTER_EN.
- RST_VAL, '1: per-channel reset/idle level, WIDTH bits; UART lines idle high.
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  asynchronous channel inputs.
- dout  output  WIDTH  synchronized (and filtered) levels, registered.
- rise  output  WIDTH  one-cycle strobe: dout[i] went 0->1 this cycle.
- fall  output  WIDTH  one-cycle strobe: dout[i] went 1->0 this cycle.

## Operation
- Channels are fully independent; no cross-channel coherence is guaranteed. Multi-bit buses must not be passed through this block.
- Sync chain: sync[0] <= din, sync[k] <= sync[k-1]. sync_out = sync[STAGES-1].
- Filter (SYNC_FILTER_EN) per channel:
  - cnt has width $clog2(FILTER_CYCLES)+1.
  - If sync_out == dout, cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1, then dout <= sync_out and cnt <= 0.
  - Else cnt <= cnt+1.
  - Consequence: a pulse shorter than FILTER_CYCLES cycles at sync_out is discarded and dout is unchanged.
- rise[i]/fall[i] are registered in the same edge that updates dout[i]: rise = new & ~old, fall = ~new & old. They are high for exactly one cycle per accepted transition.
- Reset (any cycle, including mid-filter or mid-transition):
  - All sync stages and dout <= RST_VAL.
  - cnt <= 0; rise, fall <= 0.
  - Reset itself never generates a strobe.
  - After release, a din differing from RST_VAL propagates with normal latency and produces a normal strobe.
- din toggling every cycle: dout never changes while SYNC_FILTER_EN is defined and FILTER_CYCLES > 1.

## Timing
- din is stable from before edge 1. The first edge that can capture it is edge 1.
- Without the filter, dout/rise/fall update at edge STAGES; latency is STAGES cycles.
- With the filter, dout/rise/fall update at edge STAGES+FILTER_CYCLES.
- Strobe width: 1 cycle. Minimum spacing between strobes on one channel:
  - 1 cycle without the filter.
  - FILTER_CYCLES cycles with the filter.
- Metastability is resolved in sync[0]; sync[1..] add MTBF margin. No logic reads sync[0] except sync[1].

## Configuration
- SYNC_FILTER_EN defined: filter counters are instantiated; latency is STAGES+FILTER_CYCLES.
- SYNC_FILTER_EN undefined:
  - dout <= sync_out every cycle; FILTER_CYCLES is ignored.
  - No counter flops exist; latency is STAGES.
  - rise/fall follow every sync_out change.

## Structure
- Package sync_pkg holds:
  - The default constants SYNC_STAGES_DEF = 2 and SYNC_FILTER_DEF = 4.
  - A function filt_cnt_w(n) returning the counter width.
- Sub-module glitch_filter handles one channel. It has ports clk, rst, rst_val, d, q, rise, fall and parameter FILTER_CYCLES.
- sync_filter generates WIDTH instances. Under SYNC_FILTER_EN undefined, each instance is replaced by a plain register plus edge logic.

## Test plan
Config for all scenarios: WIDTH=4, STAGES=2, FILTER_CYCLES=3, RST_VAL=4'hF.
- Reset, din=4'h0: during reset dout=4'hF, rise=fall=0. After release, bit 0 behaves as follows:
  - Filter on: dout=4'h0 with fall=4'hF, one cycle, at edge 5 after release.
  - Filter off: dout=4'h0 with fall=4'hF at edge 2.
- Filter on, din[0] pulsed low for 2 cycles: dout stays 4'hF, no strobes.
- Filter on, din[0] pulsed low for 3 cycles: fall[0] for 1 cycle, then rise[0] exactly 3 cycles later, and dout[0] returns to 1.
- din[1] toggles every cycle for 20 cycles, filter on: dout[1] constant, no strobes.
- Reset asserted while a transition is in flight:
  - Setup: din[2] has gone low and filter cnt=2.
  - Response: next cycle dout=4'hF, rise=fall=0.
  - No stale fall[2] strobe is issued after release.
- Independent channels: din=4'h0 then 4'h5 on consecutive cycles. Bits 1 and 3 see a single fall; bits 0 and 2 see no strobe with the filter on.
